// File: rtl/traffic_light_monitor.sv
// Passive checker for a traffic-light controller: follows RED->GREEN->YELLOW->RED,
// checks one-hot lights, phase order, phase length and countdown, and counts legal cycles.
module traffic_light_monitor #(
  parameter int GREEN_LEN  = 8,
  parameter int YELLOW_LEN = 3,
  parameter int RED_LEN    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       green_light,
  input  logic       yellow_light,
  input  logic       red_light,
  input  logic [3:0] cnt,
  input  logic       clr_err,
  output logic       locked,
  output logic [1:0] phase,
  output logic       err,
  output logic [2:0] err_code,
  output logic [7:0] cycle_count
);

  localparam logic [1:0] PH_NONE   = 2'd0;
  localparam logic [1:0] PH_RED    = 2'd1;
  localparam logic [1:0] PH_GREEN  = 2'd2;
  localparam logic [1:0] PH_YELLOW = 2'd3;

  localparam logic ST_SYNC  = 1'b0;
  localparam logic ST_TRACK = 1'b1;

  localparam logic [4:0] L_RED    = 5'(RED_LEN);
  localparam logic [4:0] L_GREEN  = 5'(GREEN_LEN);
  localparam logic [4:0] L_YELLOW = 5'(YELLOW_LEN);

  logic       r_state;
  logic [1:0] r_phase;
  logic [4:0] r_dur;
  logic       r_locked;
  logic       r_err;
  logic [2:0] r_err_code;
  logic [7:0] r_cycle_count;

  logic       w_onehot;
  logic [1:0] w_light;
  logic       w_same;
  logic       w_is_succ;
  logic [4:0] w_dur_inc;
  logic [4:0] w_len_cur;
  logic [4:0] w_len_new;
  logic [4:0] w_exp_same;
  logic [4:0] w_exp_new;
  logic [2:0] w_code;

  function automatic logic [4:0] len_of(input logic [1:0] p);
    case (p)
      PH_RED:    return L_RED;
      PH_GREEN:  return L_GREEN;
      PH_YELLOW: return L_YELLOW;
      default:   return 5'd0;
    endcase
  endfunction

  function automatic logic [1:0] succ_of(input logic [1:0] p);
    case (p)
      PH_RED:    return PH_GREEN;
      PH_GREEN:  return PH_YELLOW;
      PH_YELLOW: return PH_RED;
      default:   return PH_NONE;
    endcase
  endfunction

  always_comb begin
    w_onehot = 1'b1;
    w_light  = PH_NONE;
    case ({red_light, green_light, yellow_light})
      3'b100:  w_light = PH_RED;
      3'b010:  w_light = PH_GREEN;
      3'b001:  w_light = PH_YELLOW;
      default: w_onehot = 1'b0;
    endcase
    w_same     = (w_light == r_phase);
    w_is_succ  = (w_light == succ_of(r_phase));
    w_dur_inc  = r_dur + 5'd1;
    w_len_cur  = len_of(r_phase);
    w_len_new  = len_of(w_light);
    // Only meaningful while dur < LEN, so the result never wraps and bit 4 is zero.
    w_exp_same = w_len_new - 5'd1 - w_dur_inc;
    w_exp_new  = w_len_new - 5'd1;

    // Priority order makes the lowest code win when several checks fail together.
    w_code = 3'd0;
    if (!w_onehot) begin
      w_code = 3'd1;
    end else if (r_state == ST_SYNC) begin
      if (r_phase != PH_NONE && !w_same && !w_is_succ) w_code = 3'd2;
    end else if (w_same) begin
      if (w_dur_inc == w_len_cur)           w_code = 3'd4;
      else if ({1'b0, cnt} != w_exp_same)   w_code = 3'd5;
    end else if (!w_is_succ) begin
      w_code = 3'd2;
    end else if (w_dur_inc < w_len_cur) begin
      w_code = 3'd3;
    end else if ({1'b0, cnt} != w_exp_new) begin
      w_code = 3'd5;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_SYNC;
      r_phase       <= PH_NONE;
      r_dur         <= 5'd0;
      r_locked      <= 1'b0;
      r_err         <= 1'b0;
      r_err_code    <= 3'd0;
      r_cycle_count <= 8'd0;
    end else if (w_code != 3'd0) begin
      // An error in the same cycle as a clear is latched as the new first error.
      if (!r_err || clr_err) begin
        r_err      <= 1'b1;
        r_err_code <= w_code;
      end
      r_state  <= ST_SYNC;
      r_locked <= 1'b0;
      r_phase  <= w_light;
      r_dur    <= 5'd0;
    end else begin
      if (clr_err) begin
        r_err      <= 1'b0;
        r_err_code <= 3'd0;
      end
      if (r_state == ST_SYNC) begin
        r_phase <= w_light;
        r_dur   <= 5'd0;
        if (r_phase != PH_NONE && !w_same) begin
          r_state  <= ST_TRACK;
          r_locked <= 1'b1;
        end
      end else if (w_same) begin
        r_dur <= w_dur_inc;
      end else begin
        r_phase <= w_light;
        r_dur   <= 5'd0;
        // Only cycles observed while tracking count as completed.
        if (r_phase == PH_YELLOW && r_cycle_count != 8'hFF)
          r_cycle_count <= r_cycle_count + 8'd1;
      end
    end
  end

  assign locked      = r_locked;
  assign phase       = r_phase;
  assign err         = r_err;
  assign err_code    = r_err_code;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench: stimulus pushes model predictions into a queue, a monitor pops
// and compares one entry per clock after the DUT has registered the sample.
module tb_traffic_light_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       green_light = 1'b0;
  logic       yellow_light = 1'b0;
  logic       red_light = 1'b0;
  logic [3:0] cnt = 4'd0;
  logic       clr_err = 1'b0;
  logic       locked;
  logic [1:0] phase;
  logic       err;
  logic [2:0] err_code;
  logic [7:0] cycle_count;

  always #5 clk = ~clk;

  traffic_light_monitor #(.GREEN_LEN(8), .YELLOW_LEN(3), .RED_LEN(10)) dut (
    .clk(clk), .reset(reset), .green_light(green_light), .yellow_light(yellow_light),
    .red_light(red_light), .cnt(cnt), .clr_err(clr_err), .locked(locked), .phase(phase),
    .err(err), .err_code(err_code), .cycle_count(cycle_count)
  );

  typedef struct {
    logic       locked;
    logic [1:0] phase;
    logic       err;
    logic [2:0] code;
    logic [7:0] cc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: light numbers 1=red 2=green 3=yellow, 0=no legal light.
  int lens[4] = '{0, 10, 8, 3};
  bit m_sync = 1;
  int m_phase = 0, m_dur = 0, m_cc = 0, m_code = 0;
  bit m_locked = 0, m_err = 0;

  function automatic int next_of(input int p);
    return (p == 3) ? 1 : p + 1;
  endfunction

  task automatic model_step(input bit rst, input bit r, input bit g, input bit y,
                            input int c, input bit clr);
    int lt, code, nlit;
    exp_t e;
    nlit = int'(r) + int'(g) + int'(y);
    lt   = (nlit != 1) ? 0 : (r ? 1 : (g ? 2 : 3));
    code = 0;
    if (rst) begin
      m_sync = 1; m_phase = 0; m_dur = 0; m_cc = 0; m_code = 0; m_locked = 0; m_err = 0;
    end else begin
      if (lt == 0) code = 1;
      else if (m_sync) begin
        if (m_phase != 0 && lt != m_phase && lt != next_of(m_phase)) code = 2;
      end else if (lt == m_phase) begin
        if (m_dur + 1 == lens[lt]) code = 4;
        else if (c != lens[lt] - 1 - (m_dur + 1)) code = 5;
      end else if (lt != next_of(m_phase)) code = 2;
      else if (m_dur + 1 < lens[m_phase]) code = 3;
      else if (c != lens[lt] - 1) code = 5;

      if (code != 0) begin
        if (!m_err || clr) begin m_err = 1; m_code = code; end
        m_sync = 1; m_locked = 0; m_phase = lt; m_dur = 0;
      end else begin
        if (clr) begin m_err = 0; m_code = 0; end
        if (m_sync) begin
          if (m_phase != 0 && lt != m_phase) begin m_sync = 0; m_locked = 1; end
          m_phase = lt; m_dur = 0;
        end else if (lt == m_phase) m_dur++;
        else begin
          if (m_phase == 3 && m_cc < 255) m_cc++;
          m_phase = lt; m_dur = 0;
        end
      end
    end
    e.locked = m_locked; e.phase = 2'(m_phase); e.err = m_err;
    e.code = 3'(m_code); e.cc = 8'(m_cc);
    q.push_back(e);
  endtask

  task automatic step(input bit rst, input bit r, input bit g, input bit y,
                      input int c, input bit clr);
    @(negedge clk);
    reset = rst; red_light = r; green_light = g; yellow_light = y;
    cnt = 4'(c); clr_err = clr;
    model_step(rst, r, g, y, c & 15, clr);
  endtask

  // Drive light lt for n samples with a countdown starting at LEN-1; stuck freezes cnt.
  task automatic run_phase(input int lt, input int n, input bit stuck);
    for (int i = 0; i < n; i++) begin
      int c;
      c = stuck ? lens[lt] - 1 : lens[lt] - 1 - i;
      step(0, lt == 1, lt == 2, lt == 3, c & 15, 0);
    end
  endtask

  task automatic legal_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      run_phase(1, 10, 0); run_phase(2, 8, 0); run_phase(3, 3, 0);
    end
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("locked", int'(locked), int'(e.locked));
        chk("phase", int'(phase), int'(e.phase));
        chk("err", int'(err), int'(e.err));
        chk("err_code", int'(err_code), int'(e.code));
        chk("cycle_count", int'(cycle_count), int'(e.cc));
      end
    end
  end

  initial begin
    do_reset(); do_reset();
    $display("scenario: legal stream");
    legal_cycles(3); run_phase(1, 10, 0);

    $display("scenario: double light then resume");
    step(0, 1, 1, 0, 5, 0);
    legal_cycles(2);

    $display("scenario: short yellow, later long green keeps first code");
    step(0, 0, 0, 0, 0, 1);
    do_reset();
    legal_cycles(1); run_phase(1, 10, 0); run_phase(2, 8, 0); run_phase(3, 2, 0);
    run_phase(1, 10, 0); run_phase(2, 9, 0); run_phase(3, 3, 0);

    $display("scenario: long green");
    do_reset();
    legal_cycles(1); run_phase(1, 10, 0); run_phase(2, 9, 0); run_phase(3, 3, 0);

    $display("scenario: stuck cnt then clear");
    do_reset();
    legal_cycles(1); run_phase(1, 3, 1);
    step(0, 1, 0, 0, 6, 1);
    run_phase(1, 2, 0);

    $display("scenario: reset mid-green");
    do_reset();
    legal_cycles(1); run_phase(1, 10, 0); run_phase(2, 4, 0);
    do_reset();
    run_phase(2, 3, 0);

    $display("scenario: saturation");
    do_reset();
    legal_cycles(258); run_phase(1, 10, 0);

    $display("scenario: randomized");
    do_reset();
    for (int it = 0; it < 60; it++) begin
      for (int p = 1; p <= 3; p++) begin
        int n;
        n = ($urandom_range(0, 9) < 8) ? lens[p] : $urandom_range(1, lens[p] + 2);
        for (int i = 0; i < n; i++) begin
          int c, sel;
          bit rr, gg, yy, clr, rst;
          c = lens[p] - 1 - i;
          if ($urandom_range(0, 19) == 0) c = $urandom_range(0, 15);
          rr = (p == 1); gg = (p == 2); yy = (p == 3);
          sel = $urandom_range(0, 29);
          if (sel == 0) begin rr = 1'($urandom); gg = 1'($urandom); yy = 1'($urandom); end
          if (sel == 1) begin rr = (p == 2); gg = (p == 3); yy = (p == 1); end
          clr = ($urandom_range(0, 19) == 0);
          rst = ($urandom_range(0, 199) == 0);
          step(rst, rr, gg, yy, c & 15, clr);
        end
      end
    end

    @(negedge clk);
    reset = 1'b0; red_light = 1'b0; green_light = 1'b0; yellow_light = 1'b0; clr_err = 1'b0;
    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
